fetch_pipeline: RTL and testbench
=================================

Name: fetch_pipeline

Overview:
- Owns the PC and the three instruction-holding stages of the 3-stage core: FD, X and MW.
- Drives the synchronous BIOS and IMEM read ports.
- Applies the pc_sel redirect produced by the control logic and inserts bubbles on X-stage redirects.
- Supplies inst_fd / inst_x / inst_mw and their PCs to the control logic and datapath, plus cycle and instret counters for CSR reads.

Parameters:
- RESET_PC, 32'h4000_0000: first fetch address after reset (BIOS base).
- NOP_INST, 32'h0000_0013: instruction word used for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  freeze all stage registers and the PC
- pc_sel  in  2  0 = jal_target, 1 = alu_target, 2 = PC+4
- jal_target  in  32  JAL target computed in FD (pc_fd + J-imm)
- alu_target  in  32  JALR/branch target from X-stage ALU
- bios_addr  out  12  BIOS word address
- bios_dout  in  32  BIOS read data, valid one cycle after the address
- imem_addr  out  14  IMEM word address
- imem_dout  in  32  IMEM read data, valid one cycle after the address
- pc_fd, pc_x, pc_mw  out  32 each  stage PCs
- inst_fd, inst_x, inst_mw  out  32 each  stage instructions
- valid_x, valid_mw  out  1 each  0 = bubble, 1 = real instruction
- cycle_cnt  out  32  cycles since reset
- instret_cnt  out  32  instructions retired

Behaviour:
- fetch_pc (combinational next PC):
  - rst_n=0 -> RESET_PC.
  - else stall=1 -> pc_fd.
  - else pc_sel=1 -> alu_target; pc_sel=0 -> jal_target; pc_sel=2 -> pc_fd+4.
  - pc_sel=3 is treated as 2.
- Addresses: bios_addr = fetch_pc[13:2]; imem_addr = fetch_pc[15:2]. Both ports are driven every cycle.
- pc_fd <= fetch_pc every cycle, including reset and stall.
- inst_fd is combinational:
  - NOP_INST when kill_fd_q=1.
  - else bios_dout when pc_fd[30]=1.
  - else imem_dout.
- JAL has zero penalty: the target is fetched in the same cycle JAL sits in FD.
- X redirect (pc_sel=1, stall=0):
  - The FD instruction is wrong-path.
  - Next edge: inst_x <= NOP_INST, valid_x <= 0, pc_x <= pc_fd.
  - Exactly one bubble results.
  - kill_fd_q is reserved and stays 0 in this version. Implement it as a register that resets to 0.
- Normal advance (stall=0): X <= FD (valid_x <= 1 unless flushed); MW <= X (pc, inst, valid copied).
- Stall=1:
  - Every stage register and both counters except cycle_cnt hold.
  - fetch_pc=pc_fd re-presents the same address, so inst_fd stays stable on the next cycle.
  - A pc_sel redirect asserted during stall is ignored. It re-asserts when stall drops because the control inputs derive from the held stages.
- Reset (rst_n=0 at an edge):
  - pc_fd <= RESET_PC.
  - pc_x, pc_mw <= 0; inst_x, inst_mw <= NOP_INST; valid_x, valid_mw <= 0.
  - cycle_cnt, instret_cnt <= 0.
  - The first cycle after release presents inst_fd = mem[RESET_PC] with no bubble.
- Reset asserted mid-redirect or mid-stall: reset wins and all in-flight state is discarded.
- Counters:
  - cycle_cnt += 1 each non-reset cycle, stall included.
  - instret_cnt += 1 on each non-stalled cycle with valid_mw=1.
  - Both wrap modulo 2^32.
- PC arithmetic is 32-bit wraparound. Targets are not alignment-checked: bits [1:0] are ignored by the address outputs and kept in pc_fd.

Decomposition:
- Shared package riscv_consts holds:
  - NOP_INST
  - RESET_PC default
  - PC_SEL_JAL=0, PC_SEL_ALU=1, PC_SEL_PC4=2
  - OPC_* opcodes, shared with the control logic
- One natural sub-module: stage_reg (pc, inst and valid register with enable, flush, sync active-low reset), instantiated for X and MW.

Test Plan:
- Reset release at RESET_PC=0x4000_0000, no redirects, BIOS words W0..W3 -> inst_fd=W0..W3 on consecutive cycles; inst_mw=W0 on cycle 3; instret_cnt=1 after cycle 3.
- JAL in FD with pc_sel=0, jal_target=0x4000_0100 -> next cycle pc_fd=0x4000_0100, valid_x=1 for the JAL, no bubble.
- pc_sel=1 with alu_target=0x1000_0040 while FD holds 0x4000_0008 -> next cycle inst_x=0x0000_0013, valid_x=0, pc_fd=0x1000_0040 with inst_fd taken from imem_dout.
- stall=1 for 3 cycles mid-stream -> pc_fd, inst_x, inst_mw and instret_cnt hold; cycle_cnt advances by 3; bios_addr/imem_addr constant.
- rst_n=0 for one cycle during an X redirect -> pc_fd=0x4000_0000, inst_x=inst_mw=0x0000_0013, both counters 0.
- Preload instret_cnt=0xFFFF_FFFF via force, retire one instruction -> instret_cnt=0.

Source files
------------

// File: rtl/riscv_consts_pkg.sv
// Constants shared by the fetch pipeline and the control logic of the 3-stage core.
package riscv_consts;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  localparam logic [1:0] PC_SEL_JAL = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

endpackage

// File: rtl/fetch_pipeline_stage_reg.sv
// One pipeline stage register (pc, inst, valid) with enable, flush-to-bubble and sync reset.
module stage_reg #(
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        valid_in,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid
);

  // A flush keeps the PC of the squashed slot so the bubble still carries a meaningful address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= 32'd0;
      inst  <= BUBBLE_INST;
      valid <= 1'b0;
    end else if (en) begin
      pc <= pc_in;
      if (flush) begin
        inst  <= BUBBLE_INST;
        valid <= 1'b0;
      end else begin
        inst  <= inst_in;
        valid <= valid_in;
      end
    end
  end

endmodule

// File: rtl/fetch_pipeline.sv
// PC, FD/X/MW instruction stages, BIOS/IMEM fetch addressing and cycle/instret counters.
module fetch_pipeline
  import riscv_consts::*;
#(
  parameter logic [31:0] RESET_PC = riscv_consts::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = riscv_consts::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  output logic [11:0] bios_addr,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc_fd,
  output logic [31:0] pc_x,
  output logic [31:0] pc_mw,
  output logic [31:0] inst_fd,
  output logic [31:0] inst_x,
  output logic [31:0] inst_mw,
  output logic        valid_x,
  output logic        valid_mw,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  // valid_x / valid_mw: 1 = the stage holds a real instruction, 0 = bubble. There is no
  // ready path; stall freezes every stage at once, and a stage advances on each cycle stall=0.

  logic [31:0] fetch_pc;
  logic        kill_fd_q;
  logic        advance;
  logic        redirect_x;

  assign advance    = ~stall;
  assign redirect_x = (pc_sel == PC_SEL_ALU);

  always_comb begin
    fetch_pc = pc_fd + 32'd4;
    if (!rst_n) begin
      fetch_pc = RESET_PC;
    end else if (stall) begin
      fetch_pc = pc_fd;
    end else begin
      case (pc_sel)
        PC_SEL_ALU: fetch_pc = alu_target;
        PC_SEL_JAL: fetch_pc = jal_target;
        default:    fetch_pc = pc_fd + 32'd4;
      endcase
    end
  end

  // Both memories are addressed every cycle; pc_fd[30] picks which one FD reads from.
  assign bios_addr = fetch_pc[13:2];
  assign imem_addr = fetch_pc[15:2];

  always_ff @(posedge clk) begin
    pc_fd <= fetch_pc;
  end

  // Reserved FD kill; never set in this version.
  always_ff @(posedge clk) begin
    if (!rst_n) kill_fd_q <= 1'b0;
    else        kill_fd_q <= 1'b0;
  end

  always_comb begin
    if (kill_fd_q)     inst_fd = NOP_INST;
    else if (pc_fd[30]) inst_fd = bios_dout;
    else               inst_fd = imem_dout;
  end

  stage_reg #(.BUBBLE_INST(NOP_INST)) u_stage_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (advance),
    .flush    (redirect_x),
    .pc_in    (pc_fd),
    .inst_in  (inst_fd),
    .valid_in (~kill_fd_q),
    .pc       (pc_x),
    .inst     (inst_x),
    .valid    (valid_x)
  );

  stage_reg #(.BUBBLE_INST(NOP_INST)) u_stage_mw (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (advance),
    .flush    (1'b0),
    .pc_in    (pc_x),
    .inst_in  (inst_x),
    .valid_in (valid_x),
    .pc       (pc_mw),
    .inst     (inst_mw),
    .valid    (valid_mw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (advance && valid_mw) instret_cnt <= instret_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pipeline.sv
// Directed bench for fetch_pipeline: PC/FD model per cycle plus a retirement scoreboard.
module tb_fetch_pipeline;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] jal_target;
  logic [31:0] alu_target;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] pc_fd, pc_x, pc_mw;
  logic [31:0] inst_fd, inst_x, inst_mw;
  logic        valid_x, valid_mw;
  logic [31:0] cycle_cnt, instret_cnt;

  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];

  logic [63:0] exp_q [$];
  logic [31:0] m_pc;
  int          n_pass;
  int          n_total;
  logic [11:0] hold_bios_addr;
  logic [13:0] hold_imem_addr;

  fetch_pipeline dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .jal_target  (jal_target),
    .alu_target  (alu_target),
    .bios_addr   (bios_addr),
    .bios_dout   (bios_dout),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .pc_fd       (pc_fd),
    .pc_x        (pc_x),
    .pc_mw       (pc_mw),
    .inst_fd     (inst_fd),
    .inst_x      (inst_x),
    .inst_mw     (inst_mw),
    .valid_x     (valid_x),
    .valid_mw    (valid_mw),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous memories: data one cycle after the address
  always @(posedge clk) begin
    bios_dout <= bios_mem[bios_addr];
    imem_dout <= imem_mem[imem_addr];
  end

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    logic [11:0] ba;
    logic [13:0] ia;
    ba = pc[13:2];
    ia = pc[15:2];
    if (pc[30]) return bios_mem[ba];
    return imem_mem[ia];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver: inputs change 1 time unit after the active edge, results are checked there too
  task automatic step(input logic rn, input logic st, input logic [1:0] sel,
                      input logic [31:0] jt, input logic [31:0] at);
    rst_n = rn; stall = st; pc_sel = sel; jal_target = jt; alu_target = at;
    if (!rn) begin
      exp_q.delete();
      m_pc = RESET_PC;
    end else if (!st) begin
      if (sel != 2'd1) exp_q.push_back({m_pc, model_inst(m_pc)});
      case (sel)
        2'd1:    m_pc = at;
        2'd0:    m_pc = jt;
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    @(posedge clk); #1;
    check("pc_fd", {32'd0, pc_fd}, {32'd0, m_pc});
    check("inst_fd", {32'd0, inst_fd}, {32'd0, model_inst(m_pc)});
  endtask

  task automatic run(input logic [1:0] sel, input logic [31:0] jt, input logic [31:0] at);
    step(1'b1, 1'b0, sel, jt, at);
  endtask

  // monitor: a retirement happens on each edge with valid_mw=1 and stall=0
  always @(negedge clk) begin
    if (rst_n && !stall && valid_mw) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL retire_unexpected: got %h_%h expected none", pc_mw, inst_mw);
      end else begin
        check("retire", {pc_mw, inst_mw}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 4096; i++)  bios_mem[i] = 32'h00B0_0000 + i;
    for (int i = 0; i < 16384; i++) imem_mem[i] = 32'h00A0_0000 + i;
    rst_n = 1'b0; stall = 1'b0; pc_sel = 2'd2; jal_target = 32'd0; alu_target = 32'd0;
    m_pc = RESET_PC;

    // reset (E0)
    step(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
    step(1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
    check("rst_pc_fd", {32'd0, pc_fd}, {32'd0, 32'h4000_0000});
    check("rst_inst_x", {32'd0, inst_x}, {32'd0, NOP});
    check("rst_inst_mw", {32'd0, inst_mw}, {32'd0, NOP});
    check("rst_valids", {62'd0, valid_x, valid_mw}, 64'd0);
    check("rst_cycle", {32'd0, cycle_cnt}, 64'd0);
    check("rst_instret", {32'd0, instret_cnt}, 64'd0);
    check("first_fetch_W0", {32'd0, inst_fd}, {32'd0, 32'h00B0_0000});

    // straight-line BIOS fetch
    run(2'd2, 32'd0, 32'd0);  // E1
    check("W1_fd", {32'd0, inst_fd}, {32'd0, 32'h00B0_0001});
    check("W0_x", {31'd0, valid_x, inst_x}, {31'd0, 1'b1, 32'h00B0_0000});
    run(2'd2, 32'd0, 32'd0);  // E2
    check("W0_mw", {32'd0, inst_mw}, {32'd0, 32'h00B0_0000});
    check("instret_E2", {32'd0, instret_cnt}, 64'd0);
    run(2'd2, 32'd0, 32'd0);  // E3
    check("W3_fd", {32'd0, inst_fd}, {32'd0, 32'h00B0_0003});
    check("instret_E3", {32'd0, instret_cnt}, 64'd1);

    // JAL in FD: zero-penalty redirect
    run(2'd0, 32'h4000_0100, 32'd0);  // E4
    check("jal_pc_fd", {32'd0, pc_fd}, {32'd0, 32'h4000_0100});
    check("jal_x", {pc_x, inst_x}, {32'h4000_000C, 32'h00B0_0003});
    check("jal_valid_x", {63'd0, valid_x}, 64'd1);
    run(2'd0, 32'h4000_0008, 32'd0);  // E5, back so FD holds 0x4000_0008

    // X redirect into IMEM: one bubble
    run(2'd1, 32'd0, 32'h1000_0040);  // E6
    check("alu_pc_fd", {32'd0, pc_fd}, {32'd0, 32'h1000_0040});
    check("alu_inst_fd", {32'd0, inst_fd}, {32'd0, 32'h00A0_0010});
    check("alu_bubble", {31'd0, valid_x, inst_x}, {31'd0, 1'b0, NOP});
    check("alu_bubble_pc", {32'd0, pc_x}, {32'd0, 32'h4000_0008});
    run(2'd2, 32'd0, 32'd0);  // E7
    run(2'd2, 32'd0, 32'd0);  // E8
    check("instret_E8", {32'd0, instret_cnt}, 64'd5);
    check("cycle_E8", {32'd0, cycle_cnt}, 64'd8);

    // stall for 3 cycles; a redirect raised meanwhile must be ignored
    hold_bios_addr = 12'h012;
    hold_imem_addr = 14'h0012;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, (i == 1) ? 2'd1 : 2'd2, 32'h0, 32'hDEAD_BEE0);
      check("stall_bios_addr", {52'd0, bios_addr}, {52'd0, hold_bios_addr});
      check("stall_imem_addr", {50'd0, imem_addr}, {50'd0, hold_imem_addr});
      check("stall_x", {32'd0, inst_x}, {32'd0, 32'h00A0_0011});
      check("stall_mw", {32'd0, inst_mw}, {32'd0, 32'h00A0_0010});
      check("stall_instret", {32'd0, instret_cnt}, 64'd5);
    end
    check("stall_cycle", {32'd0, cycle_cnt}, 64'd11);
    run(2'd2, 32'd0, 32'd0);  // E12
    check("unstall_instret", {32'd0, instret_cnt}, 64'd6);

    // reset during an X redirect
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'd1, 32'd0, 32'h1000_0100);  // E13
    check("rstmid_pc_fd", {32'd0, pc_fd}, {32'd0, 32'h4000_0000});
    check("rstmid_insts", {inst_x, inst_mw}, {NOP, NOP});
    check("rstmid_cnts", {cycle_cnt, instret_cnt}, 64'd0);

    // instret wraparound
    run(2'd2, 32'd0, 32'd0);  // E14
    run(2'd2, 32'd0, 32'd0);  // E15, W0 now in MW
    force dut.instret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt;
    run(2'd2, 32'd0, 32'd0);  // E16, W0 retires
    check("instret_wrap", {32'd0, instret_cnt}, 64'd0);
    check("cycle_after_rst", {32'd0, cycle_cnt}, 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
